// File: rtl/rx_frame_controller.sv
// Validates completed SPI frames, latches good ones atomically into the command register and runs the link-health/ESTOP FSM.
// Optional: define FRAME_COUNTER_EN to build the 8-bit good-frame counter driving frame_count (tied to 0 otherwise).

module rx_frame_controller #(
  parameter int unsigned BUFFER_SIZE    = 240,
  parameter logic [31:0] RX_MAGIC       = 32'h74697277,
  parameter int unsigned TIMEOUT_CYCLES = 4800000,
  parameter int unsigned BAD_LIMIT      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_valid,
  input  logic [BUFFER_SIZE-1:0] rx_data,
  input  logic                   estop_in,
  output logic [BUFFER_SIZE-1:0] cmd_data,
  output logic                   data_valid,
  output logic [31:0]            header_tx,
  output logic                   error,
  output logic                   timeout,
  output logic                   estop,
  output logic [7:0]             frame_count
);

  localparam int unsigned   TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    BAD_LIM   = 4'(BAD_LIMIT);
  localparam logic [31:0]   HDR_DATA  = 32'h64617461;
  localparam logic [31:0]   HDR_ESTOP = 32'h65737470;

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_TIMEOUT,
    S_ESTOP
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [BUFFER_SIZE-1:0] cmd_reg;
  logic [TW-1:0]          tmo_cnt;
  logic [3:0]             bad_cnt;
  logic [3:0]             bad_inc;
  logic [31:0]            hdr;
  logic                   good;
  logic                   bad;
  logic                   bad_limit_hit;
  logic                   enables_clear;
  logic                   take;

  // Header bytes arrive little-endian from the top of the shift buffer.
  always_comb begin
    hdr = {rx_data[BUFFER_SIZE-25 -: 8], rx_data[BUFFER_SIZE-17 -: 8],
           rx_data[BUFFER_SIZE-9 -: 8],  rx_data[BUFFER_SIZE-1 -: 8]};
    good          = frame_valid && (hdr == RX_MAGIC);
    bad           = frame_valid && !good;
    bad_inc       = (bad_cnt == 4'hF) ? bad_cnt : bad_cnt + 4'd1;
    bad_limit_hit = bad && (bad_inc >= BAD_LIM);
    enables_clear = (rx_data[15:8] == 8'h00);
  end

  // Event priority: estop_in, then bad-header limit, then good frame, then timeout.
  always_comb begin
    state_next = state;
    take       = 1'b0;
    case (state)
      S_INIT: begin
        if (good) begin
          take       = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (estop_in || bad_limit_hit) begin
          state_next = S_ESTOP;
        end else if (good) begin
          take = 1'b1;
        end else if (tmo_cnt >= TMO_LAST) begin
          state_next = S_TIMEOUT;
        end
      end
      S_TIMEOUT: begin
        if (estop_in) begin
          state_next = S_ESTOP;
        end else if (good) begin
          take       = 1'b1;
          state_next = S_RUN;
        end
      end
      S_ESTOP: begin
        if (good && !estop_in && enables_clear) begin
          state_next = S_INIT;
        end
      end
      default: state_next = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_INIT;
      cmd_reg    <= '0;
      data_valid <= 1'b0;
      header_tx  <= HDR_DATA;
      error      <= 1'b1;
      timeout    <= 1'b0;
      estop      <= 1'b0;
      tmo_cnt    <= '0;
      bad_cnt    <= '0;
    end else begin
      state      <= state_next;
      data_valid <= take;
      if (take) begin
        cmd_reg <= rx_data;
      end

      if (take) begin
        bad_cnt <= '0;
      end else if (bad) begin
        bad_cnt <= bad_inc;
      end

      if (state_next != S_RUN || take) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt != '1) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end

      error     <= (state_next != S_RUN);
      timeout   <= (state_next == S_TIMEOUT);
      estop     <= (state_next == S_ESTOP);
      header_tx <= (state_next == S_ESTOP) ? HDR_ESTOP : HDR_DATA;
    end
  end

  // Joint enables are only visible to consumers while the link is healthy.
  assign cmd_data = {cmd_reg[BUFFER_SIZE-1:16],
                     cmd_reg[15:8] & {8{state == S_RUN}},
                     cmd_reg[7:0]};

`ifdef FRAME_COUNTER_EN
  logic [7:0] good_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      good_cnt <= '0;
    end else if (take) begin
      good_cnt <= good_cnt + 8'd1;
    end
  end

  assign frame_count = good_cnt;
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_rx_frame_controller.sv
// Self-checking bench for rx_frame_controller: directed vector table, timeout/reset/counter sequences
// and a randomized phase checked against a behavioural link model.

module tb_rx_frame_controller;

  localparam int          BS       = 240;
  localparam logic [31:0] MAGIC    = 32'h74697277;
  localparam logic [31:0] BADHDR   = 32'hDEADBEEF;
  localparam int          TMO      = 64;
  localparam int          LIM      = 4;
  localparam logic [31:0] TX_DATA  = 32'h64617461;
  localparam logic [31:0] TX_ESTOP = 32'h65737470;

  localparam int LINK_WAIT    = 0;
  localparam int LINK_UP      = 1;
  localparam int LINK_LOST    = 2;
  localparam int LINK_STOPPED = 3;

`ifdef FRAME_COUNTER_EN
  localparam logic [7:0] FC_AFTER_257 = 8'd1;
`else
  localparam logic [7:0] FC_AFTER_257 = 8'd0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          frame_valid = 1'b0;
  logic          estop_in = 1'b0;
  logic [BS-1:0] rx_data = '0;
  logic [BS-1:0] cmd_data;
  logic          data_valid;
  logic [31:0]   header_tx;
  logic          error;
  logic          timeout;
  logic          estop;
  logic [7:0]    frame_count;

  int n_checks = 0;
  int n_fail   = 0;

  int            mode;
  int            m_bad;
  int            m_last;
  int            m_frames;
  int            edge_no = 0;
  logic [BS-1:0] m_cmd;
  logic          m_dv;

  always #5 clk = ~clk;

  rx_frame_controller #(
    .BUFFER_SIZE(BS),
    .RX_MAGIC(MAGIC),
    .TIMEOUT_CYCLES(TMO),
    .BAD_LIMIT(LIM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_valid(frame_valid),
    .rx_data(rx_data),
    .estop_in(estop_in),
    .cmd_data(cmd_data),
    .data_valid(data_valid),
    .header_tx(header_tx),
    .error(error),
    .timeout(timeout),
    .estop(estop),
    .frame_count(frame_count)
  );

  task automatic chk_vec(input string name, input logic [BS-1:0] act, input logic [BS-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  function automatic logic [BS-1:0] mk_frame(input logic [31:0] hdr, input logic [7:0] en,
                                             input int unsigned seed);
    logic [BS-1:0] f;
    f = '0;
    for (int i = 0; i < BS / 8; i++) f[8*i +: 8] = 8'(seed * 37 + i * 11 + (seed >> 5));
    for (int b = 0; b < 4; b++) f[BS-1-8*b -: 8] = hdr[8*b +: 8];
    f[15:8] = en;
    return f;
  endfunction

  function automatic logic [31:0] hdr_of(input logic [BS-1:0] rx);
    logic [31:0] h;
    for (int b = 0; b < 4; b++) h[8*b +: 8] = rx[BS-1-8*b -: 8];
    return h;
  endfunction

  task automatic model_reset();
    mode     = LINK_WAIT;
    m_bad    = 0;
    m_last   = 0;
    m_frames = 0;
    m_cmd    = '0;
    m_dv     = 1'b0;
  endtask

  task automatic model_edge(input logic fv, input logic [BS-1:0] rx, input logic est);
    bit good, bad, take;
    good = fv && (hdr_of(rx) == MAGIC);
    bad  = fv && !good;
    take = 0;
    edge_no++;
    case (mode)
      LINK_WAIT: if (good) begin take = 1; mode = LINK_UP; end
      LINK_UP: begin
        if (est) mode = LINK_STOPPED;
        else if (bad && m_bad + 1 >= LIM) mode = LINK_STOPPED;
        else if (good) take = 1;
        else if (edge_no - m_last >= TMO) mode = LINK_LOST;
      end
      LINK_LOST: begin
        if (est) mode = LINK_STOPPED;
        else if (good) begin take = 1; mode = LINK_UP; end
      end
      default: if (good && !est && rx[15:8] == 8'h00) mode = LINK_WAIT;
    endcase
    if (take) begin
      m_cmd  = rx;
      m_last = edge_no;
      m_bad  = 0;
`ifdef FRAME_COUNTER_EN
      m_frames = (m_frames + 1) % 256;
`endif
    end else if (bad && m_bad < 15) begin
      m_bad++;
    end
    m_dv = take;
  endtask

  task automatic check_outputs(input string tag);
    logic [BS-1:0] ec;
    ec = m_cmd;
    if (mode != LINK_UP) ec[15:8] = '0;
    chk_vec({tag, ".cmd_data"}, cmd_data, ec);
    chk_bit({tag, ".data_valid"}, data_valid, m_dv);
    chk_bit({tag, ".error"}, error, mode != LINK_UP);
    chk_bit({tag, ".timeout"}, timeout, mode == LINK_LOST);
    chk_bit({tag, ".estop"}, estop, mode == LINK_STOPPED);
    chk_vec({tag, ".header_tx"}, {{(BS-32){1'b0}}, header_tx},
            {{(BS-32){1'b0}}, (mode == LINK_STOPPED) ? TX_ESTOP : TX_DATA});
    chk_vec({tag, ".frame_count"}, {{(BS-8){1'b0}}, frame_count}, {{(BS-8){1'b0}}, 8'(m_frames)});
  endtask

  task automatic step(input logic fv, input logic [BS-1:0] rx, input logic est, input string tag);
    frame_valid = fv;
    rx_data     = rx;
    estop_in    = est;
    @(posedge clk);
    model_edge(fv, rx, est);
    #1;
    frame_valid = 1'b0;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #2;
    model_reset();
    check_outputs(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        fv;
    logic [31:0] hdr;
    logic [7:0]  en;
    logic        est;
    logic        e_dv;
    logic        e_err;
    logic        e_to;
    logic        e_es;
    logic [7:0]  e_en;
    int          src;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [BS-1:0] f, f2, f3, exp;
    logic          est_lvl;
    logic          fv;
    logic [31:0]   hdr;
    logic [7:0]    en;
    int            dens, r;

    //            fv    hdr     en     est   dv    err   to    es    en_out src
    tbl[0]  = '{1'b1, MAGIC,  8'h1F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h1F, 0};
    tbl[1]  = '{1'b0, MAGIC,  8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h1F, 0};
    tbl[2]  = '{1'b1, BADHDR, 8'h1F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h1F, 0};
    tbl[3]  = '{1'b1, MAGIC,  8'h2A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h2A, 3};
    tbl[4]  = '{1'b1, BADHDR, 8'h2A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h2A, 3};
    tbl[5]  = '{1'b1, BADHDR, 8'h2A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h2A, 3};
    tbl[6]  = '{1'b1, BADHDR, 8'h2A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h2A, 3};
    tbl[7]  = '{1'b1, BADHDR, 8'h2A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 3};
    tbl[8]  = '{1'b1, MAGIC,  8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 3};
    tbl[9]  = '{1'b1, MAGIC,  8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 3};
    tbl[10] = '{1'b1, MAGIC,  8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3};
    tbl[11] = '{1'b1, MAGIC,  8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 11};
    tbl[12] = '{1'b1, MAGIC,  8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 11};
    tbl[13] = '{1'b0, MAGIC,  8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 11};

    model_reset();
    #2;
    do_reset("reset");

    for (int i = 0; i < 14; i++) begin
      f = mk_frame(tbl[i].hdr, tbl[i].en, i);
      step(tbl[i].fv, f, tbl[i].est, $sformatf("vec%0d.model", i));
      exp = mk_frame(tbl[tbl[i].src].hdr, tbl[tbl[i].src].en, tbl[i].src);
      exp[15:8] = tbl[i].e_en;
      chk_vec($sformatf("vec%0d.cmd_data", i), cmd_data, exp);
      chk_bit($sformatf("vec%0d.data_valid", i), data_valid, tbl[i].e_dv);
      chk_bit($sformatf("vec%0d.error", i), error, tbl[i].e_err);
      chk_bit($sformatf("vec%0d.timeout", i), timeout, tbl[i].e_to);
      chk_bit($sformatf("vec%0d.estop", i), estop, tbl[i].e_es);
      chk_vec($sformatf("vec%0d.header_tx", i), {{(BS-32){1'b0}}, header_tx},
              {{(BS-32){1'b0}}, tbl[i].e_es ? TX_ESTOP : TX_DATA});
    end

    do_reset("reset2");
    f = mk_frame(MAGIC, 8'h1F, 100);
    step(1'b1, f, 1'b0, "to.enter");
    chk_bit("to.enter.error", error, 1'b0);
    for (int i = 0; i < TMO - 1; i++) step(1'b0, '0, 1'b0, "to.idle");
    chk_bit("to.last_run.timeout", timeout, 1'b0);
    step(1'b0, '0, 1'b0, "to.fire");
    chk_bit("to.fire.timeout", timeout, 1'b1);
    chk_bit("to.fire.error", error, 1'b1);
    exp = f;
    exp[15:8] = 8'h00;
    chk_vec("to.fire.cmd_data", cmd_data, exp);
    f2 = mk_frame(MAGIC, 8'h07, 101);
    step(1'b1, f2, 1'b0, "to.recover");
    chk_bit("to.recover.error", error, 1'b0);
    chk_bit("to.recover.data_valid", data_valid, 1'b1);
    chk_vec("to.recover.cmd_data", cmd_data, f2);
    for (int i = 0; i < TMO - 1; i++) step(1'b0, '0, 1'b0, "to.idle2");
    f3 = mk_frame(MAGIC, 8'h0E, 102);
    step(1'b1, f3, 1'b0, "to.race");
    chk_bit("to.race.timeout", timeout, 1'b0);
    chk_bit("to.race.error", error, 1'b0);
    chk_bit("to.race.data_valid", data_valid, 1'b1);
    for (int i = 0; i < TMO - 1; i++) step(1'b0, '0, 1'b0, "to.idle3");
    chk_bit("to.cleared.timeout", timeout, 1'b0);
    step(1'b0, '0, 1'b0, "to.fire2");
    chk_bit("to.fire2.timeout", timeout, 1'b1);

    est_lvl = 1'b0;
    for (int blk = 0; blk < 40; blk++) begin
      dens = $urandom_range(0, 2);
      for (int c = 0; c < 100; c++) begin
        if (est_lvl) begin
          if ($urandom_range(0, 19) == 0) est_lvl = 1'b0;
        end else if ($urandom_range(0, 199) == 0) begin
          est_lvl = 1'b1;
        end
        if (dens == 0) fv = ($urandom_range(0, 59) == 0);
        else if (dens == 1) fv = ($urandom_range(0, 3) == 0);
        else fv = ($urandom_range(0, 3) != 0);
        r = $urandom_range(0, 7);
        if (r < 5) hdr = MAGIC;
        else if (r == 5) hdr = MAGIC ^ (32'h1 << $urandom_range(0, 31));
        else hdr = $urandom;
        en = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
        step(fv, mk_frame(hdr, en, $urandom), est_lvl, "rand");
      end
    end

    step(1'b1, mk_frame(MAGIC, 8'h00, 5), 1'b0, "pre_rst.a");
    step(1'b1, mk_frame(MAGIC, 8'h00, 6), 1'b0, "pre_rst.b");
    step(1'b1, mk_frame(MAGIC, 8'hA5, 7), 1'b0, "pre_rst.c");
    chk_bit("pre_rst.error", error, 1'b0);
    do_reset("async_rst");
    chk_bit("async_rst.error", error, 1'b1);
    chk_vec("async_rst.cmd_data", cmd_data, '0);
    chk_vec("async_rst.header_tx", {{(BS-32){1'b0}}, header_tx}, {{(BS-32){1'b0}}, TX_DATA});

    for (int i = 0; i < 257; i++) begin
      step(1'b1, mk_frame(MAGIC, 8'((i % 255) + 1), 200 + i), 1'b0, "fcnt");
    end
    chk_vec("fcnt.after_257", {{(BS-8){1'b0}}, frame_count}, {{(BS-8){1'b0}}, FC_AFTER_257});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_frame_controller.md
Name: rx_frame_controller

Overview:
- Sits between the SPI slave interface and the joint, vout and dout consumers.
- On each completed SPI frame it validates the header and latches the frame atomically into a command register.
- Runs the link-health/ESTOP state machine and generates the tx header word and the ERROR signal.
- Consumers read only its masked command output, never the raw shift buffer.

Parameters:
- BUFFER_SIZE, 240, frame width in bits; multiple of 8, at least 48.
- RX_MAGIC, 32'h74697277, required host header value.
- TIMEOUT_CYCLES, 4800000, clk cycles without a good frame before TIMEOUT (100 ms at 48 MHz).
- BAD_LIMIT, 4, consecutive bad-header frames that force ESTOP; range 1..15.

Ports:
- clk, input, 1, system clock (sysclk).
- rst, input, 1, reset.
- frame_valid, input, 1, single-cycle strobe from the SPI slave when a frame completes.
- rx_data, input, BUFFER_SIZE, raw received frame; stable while frame_valid is high.
- estop_in, input, 1, external emergency stop, level, already synchronised.
- cmd_data, output, BUFFER_SIZE, latched frame; bits [15:8] (joint enables) forced to 0 unless in RUN.
- data_valid, output, 1, one-cycle pulse when cmd_data is updated.
- header_tx, output, 32, tx header word.
- error, output, 1, high in every state except RUN.
- timeout, output, 1, high in TIMEOUT.
- estop, output, 1, high in ESTOP.
- frame_count, output, 8, good-frame counter (see Optional Feature).

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values: state INIT, cmd_data 0, data_valid 0, header_tx 32'h64617461, error 1, timeout 0, estop 0, frame_count 0, timeout counter 0, bad counter 0.
- Header extraction (little-endian bytes): hdr = {rx_data[BS-25:BS-32], rx_data[BS-17:BS-24], rx_data[BS-9:BS-16], rx_data[BS-1:BS-8]}, where BS = BUFFER_SIZE.
- Good frame: frame_valid=1 and hdr==RX_MAGIC. Bad frame: frame_valid=1 and hdr!=RX_MAGIC.
- Good frame outside ESTOP:
  - Latch rx_data into the command register.
  - Pulse data_valid on the next cycle (latency 1).
  - Clear the timeout counter and bad counter.
- Bad frame:
  - cmd_data unchanged, no data_valid pulse.
  - Bad counter increments, saturating at 15.
- Timeout counter: increments every cycle in RUN; saturates; held at 0 in other states.
- States:
  - INIT: good frame -> RUN.
  - RUN:
    - estop_in -> ESTOP.
    - bad counter reaches BAD_LIMIT -> ESTOP.
    - counter == TIMEOUT_CYCLES-1 with no good frame this cycle -> TIMEOUT.
  - TIMEOUT: good frame -> RUN; estop_in -> ESTOP.
  - ESTOP:
    - Frames are not latched.
    - Exit to INIT only when estop_in==0 and a good frame arrives with rx_data[15:8]==0 (host has dropped all enables).
    - That clearing frame is not latched.
- Priority when events coincide: estop_in > bad limit > good frame > timeout.
  - A good frame arriving in the same cycle the timeout would fire keeps the state in RUN.
- State outputs (registered, changing the cycle after the transition):
  - header_tx: 32'h65737470 in ESTOP, 32'h64617461 otherwise.
  - error: 1 in INIT, TIMEOUT and ESTOP; 0 only in RUN.
- Enable masking: cmd_data[15:8] is combinationally masked by (state==RUN); all other bits hold the last latched value in every state.
- Reset mid-frame: the frame is discarded; all state returns to reset values.

Optional Feature:
- Macro: FRAME_COUNTER_EN.
- Defined: frame_count increments on every latched good frame, wrapping 255->0, so the host can detect dropped frames.
- Undefined: frame_count is tied to 0 and no counter register is built.

Test Plan:
- Reset, then a good frame with rx_data[15:8]=8'h1F -> RUN one cycle later; data_valid pulses once; cmd_data[15:8]=8'h1F; error=0.
- In RUN, no frames for 4800000 cycles -> timeout=1, error=1, cmd_data[15:8]=0 while other bits are kept; next good frame -> RUN.
- 4 consecutive frames with header 32'hDEADBEEF -> ESTOP, header_tx=32'h65737470; a good frame with enables 8'h01 stays in ESTOP; a good frame with enables 8'h00 and estop_in=0 -> INIT.
- estop_in rising in the same cycle as a good frame -> ESTOP; cmd_data not updated; no data_valid pulse.
- With FRAME_COUNTER_EN defined, 257 good frames -> frame_count=1.
- Assert rst mid-RUN -> all outputs return to reset values immediately (asynchronously).
